// File: rtl/n_search.sv
// n_search: binary-search controller driving the b side of a magnitude comparator.
// It proposes guesses, consumes gt/eq/lt feedback about a hidden secret and
// narrows [lo, hi] until eq reports the secret.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   PROBE | guess on the bus, waiting for qualified feedback
//   DONE  | secret found, found/steps held until start or reset
//   ERR   | inconsistent or illegal feedback, state held until start
//
// All outputs come from flops. The next guess is computed from the next lo/hi
// and registered, so feedback never reaches an output combinationally.
module n_search #(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [WIDTH-1:0]  guess,
   output logic              guess_valid,
   input  logic              fb_valid,
   input  logic              gt,
   input  logic              eq,
   input  logic              lt,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [WIDTH-1:0]  found,
   output logic [STEP_W-1:0] steps
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PROBE = 2'd1,
      DONE  = 2'd2,
      ERR   = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0]  RANGE_MAX = {WIDTH{1'b1}};
   localparam logic [STEP_W-1:0] STEP_MAX  = {STEP_W{1'b1}};

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo_nxt;
   logic [WIDTH-1:0]   hi_nxt;
   logic [WIDTH-1:0]   found_nxt;
   logic [STEP_W-1:0]  steps_nxt;
   logic [WIDTH-1:0]   guess_nxt;
   logic [WIDTH-1:0]   mid;
   logic               accept;

   // Midpoint with a one-bit-wider sum so lo+hi never overflows.
   function automatic logic [WIDTH-1:0] mid_of(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return WIDTH'(sum >> 1);
   endfunction

   assign mid    = mid_of(lo, hi);
   assign accept = (state == PROBE) && fb_valid && guess_valid;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and next-datapath decode; every register holds by default.
   always_comb begin
      state_nxt = state;
      lo_nxt    = lo;
      hi_nxt    = hi;
      found_nxt = found;
      steps_nxt = steps;

      case (state)
         IDLE, DONE, ERR: begin
            // start wins over any feedback present in the same cycle
            if (start) begin
               state_nxt = PROBE;
               lo_nxt    = '0;
               hi_nxt    = RANGE_MAX;
               found_nxt = '0;
               steps_nxt = '0;
            end
         end
         PROBE: begin
            if (accept) begin
               if (steps != STEP_MAX) begin
                  steps_nxt = steps + STEP_W'(1);
               end
               case ({gt, eq, lt})
                  3'b010: begin
                     found_nxt = mid;
                     state_nxt = DONE;
                  end
                  3'b100: begin
                     // mid==hi means the responder contradicts earlier answers
                     if (mid == hi) begin
                        state_nxt = ERR;
                     end else begin
                        lo_nxt = mid + WIDTH'(1);
                     end
                  end
                  3'b001: begin
                     if (mid == lo) begin
                        state_nxt = ERR;
                     end else begin
                        hi_nxt = mid - WIDTH'(1);
                     end
                  end
                  default: begin
                     state_nxt = ERR;
                  end
               endcase
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Guess tracks the midpoint of the range we are about to probe; outside
      // PROBE the last guess is simply held.
      guess_nxt = guess;
      if (state_nxt == PROBE) begin
         guess_nxt = mid_of(lo_nxt, hi_nxt);
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo          <= '0;
         hi          <= '0;
         found       <= '0;
         steps       <= '0;
         guess       <= '0;
         guess_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         lo          <= lo_nxt;
         hi          <= hi_nxt;
         found       <= found_nxt;
         steps       <= steps_nxt;
         guess       <= guess_nxt;
         guess_valid <= (state_nxt == PROBE);
         busy        <= (state_nxt == PROBE);
         done        <= (state_nxt == DONE);
         err         <= (state_nxt == ERR);
      end
   end

endmodule

// File: tb/tb_n_search.sv
// Directed bench for n_search: a behavioural comparator (or scripted responder)
// answers each guess; expected guess sequences are worked out by hand.
module tb_n_search;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] guess;
   logic       guess_valid;
   logic       fb_valid;
   logic       gt;
   logic       eq;
   logic       lt;
   logic       busy;
   logic       done;
   logic       err;
   logic [3:0] found;
   logic [3:0] steps;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   n_search #(.WIDTH(4), .STEP_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .guess(guess), .guess_valid(guess_valid),
      .fb_valid(fb_valid), .gt(gt), .eq(eq), .lt(lt),
      .busy(busy), .done(done), .err(err),
      .found(found), .steps(steps)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   // Pulse start for one edge; returns at the following negedge.
   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Walk exp_q: check each guess, then answer (mode 0: comparator vs secret,
   // mode 1: always gt). Returns at the negedge after the last answer.
   task automatic run_probes(input int secret, input int mode);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (guess_valid !== 1'b1 || guess !== 4'(exp_q[i])) begin
            errors++;
            $display("FAIL probe%0d: guess=%0d valid=%b, expected guess=%0d valid=1",
                     i, guess, guess_valid, exp_q[i]);
         end
         fb_valid = 1'b1;
         if (mode == 1) begin
            {gt, eq, lt} = 3'b100;
         end else begin
            gt = (secret > int'(guess));
            eq = (secret == int'(guess));
            lt = (secret < int'(guess));
         end
         @(posedge clk);
         @(negedge clk);
      end
      fb_valid = 1'b0;
      {gt, eq, lt} = 3'b000;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({guess, guess_valid, busy, done, err, found, steps} !== 16'h0000) begin
         errors++;
         $display("FAIL reset: guess=%0d gv=%b busy=%b done=%b err=%b found=%0d steps=%0d, expected all 0",
                  guess, guess_valid, busy, done, err, found, steps);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({guess_valid, busy, done, err} !== 4'b0000) begin
         errors++;
         $display("FAIL idle_after_reset: gv/busy/done/err=%b, expected 0000",
                  {guess_valid, busy, done, err});
      end
   endtask

   task automatic test_search(input int secret, input int exp_steps);
      do_start();
      run_probes(secret, 0);
      checks++;
      if ({done, err, guess_valid, busy} !== 4'b1000 || found !== 4'(secret)
          || steps !== 4'(exp_steps)) begin
         errors++;
         $display("FAIL search%0d: done=%b err=%b gv=%b busy=%b found=%0d steps=%0d, expected done=1 err=0 gv=0 busy=0 found=%0d steps=%0d",
                  secret, done, err, guess_valid, busy, found, steps, secret, exp_steps);
      end
   endtask

   task automatic test_always_gt();
      exp_q = '{7, 11, 13, 14, 15};
      do_start();
      run_probes(0, 1);
      checks++;
      if ({done, err, guess_valid} !== 3'b010 || steps !== 4'd5) begin
         errors++;
         $display("FAIL always_gt: done=%b err=%b gv=%b steps=%0d, expected done=0 err=1 gv=0 steps=5",
                  done, err, guess_valid, steps);
      end
   endtask

   task automatic test_illegal();
      do_start();
      fb_valid = 1'b1;
      {gt, eq, lt} = 3'b101;
      @(posedge clk);
      @(negedge clk);
      fb_valid = 1'b0;
      {gt, eq, lt} = 3'b000;
      checks++;
      if ({err, done, guess_valid} !== 3'b100 || steps !== 4'd1) begin
         errors++;
         $display("FAIL illegal_gt_lt: err=%b done=%b gv=%b steps=%0d, expected err=1 done=0 gv=0 steps=1",
                  err, done, guess_valid, steps);
      end
      do_start();
      checks++;
      if (err !== 1'b0 || guess !== 4'd7 || steps !== 4'd0) begin
         errors++;
         $display("FAIL restart_from_err: err=%b guess=%0d steps=%0d, expected err=0 guess=7 steps=0",
                  err, guess, steps);
      end
      fb_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      fb_valid = 1'b0;
      checks++;
      if (err !== 1'b1 || steps !== 4'd1) begin
         errors++;
         $display("FAIL illegal_no_flag: err=%b steps=%0d, expected err=1 steps=1", err, steps);
      end
      // fb_valid outside PROBE must not change anything
      fb_valid = 1'b1;
      {gt, eq, lt} = 3'b010;
      @(posedge clk);
      @(negedge clk);
      fb_valid = 1'b0;
      {gt, eq, lt} = 3'b000;
      checks++;
      if (err !== 1'b1 || done !== 1'b0 || steps !== 4'd1) begin
         errors++;
         $display("FAIL fb_in_err: err=%b done=%b steps=%0d, expected err=1 done=0 steps=1",
                  err, done, steps);
      end
   endtask

   task automatic test_stall();
      do_start();
      for (int i = 0; i < 3; i++) begin
         start = (i == 1);
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         checks++;
         if (guess !== 4'd7 || steps !== 4'd0 || {guess_valid, busy} !== 2'b11) begin
            errors++;
            $display("FAIL stall%0d: guess=%0d steps=%0d gv=%b busy=%b, expected guess=7 steps=0 gv=1 busy=1",
                     i, guess, steps, guess_valid, busy);
         end
      end
      fb_valid = 1'b1;
      {gt, eq, lt} = 3'b001;
      @(posedge clk);
      @(negedge clk);
      fb_valid = 1'b0;
      {gt, eq, lt} = 3'b000;
      checks++;
      if (guess !== 4'd3 || steps !== 4'd1 || guess_valid !== 1'b1) begin
         errors++;
         $display("FAIL after_stall: guess=%0d steps=%0d gv=%b, expected guess=3 steps=1 gv=1",
                  guess, steps, guess_valid);
      end
   endtask

   task automatic test_reset_mid_search();
      // leave the stalled PROBE from the previous test via reset first
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      exp_q = '{7};
      do_start();
      run_probes(11, 0);
      checks++;
      if (guess !== 4'd11 || busy !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: guess=%0d busy=%b, expected guess=11 busy=1", guess, busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({guess, guess_valid, busy, done, err, found, steps} !== 16'h0000) begin
         errors++;
         $display("FAIL async_reset: guess=%0d gv=%b busy=%b done=%b err=%b found=%0d steps=%0d, expected all 0",
                  guess, guess_valid, busy, done, err, found, steps);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_q = '{7, 3, 5};
      test_search(5, 3);
   endtask

   task automatic test_restart_in_done();
      // eq offered in the same cycle as start must be ignored
      start = 1'b1;
      fb_valid = 1'b1;
      {gt, eq, lt} = 3'b010;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      fb_valid = 1'b0;
      {gt, eq, lt} = 3'b000;
      checks++;
      if (guess !== 4'd7 || {guess_valid, busy, done, err} !== 4'b1100
          || steps !== 4'd0 || found !== 4'd0) begin
         errors++;
         $display("FAIL restart_done: guess=%0d gv=%b busy=%b done=%b err=%b steps=%0d found=%0d, expected guess=7 gv=1 busy=1 done=0 err=0 steps=0 found=0",
                  guess, guess_valid, busy, done, err, steps, found);
      end
   endtask

   initial begin
      rst_n    = 1'b1;
      start    = 1'b0;
      fb_valid = 1'b0;
      gt       = 1'b0;
      eq       = 1'b0;
      lt       = 1'b0;
      @(negedge clk);
      test_reset();
      exp_q = '{7, 11};
      test_search(11, 2);
      exp_q = '{7, 3, 1, 0};
      test_search(0, 4);
      exp_q = '{7, 11, 13, 14, 15};
      test_search(15, 5);
      test_always_gt();
      test_illegal();
      test_stall();
      test_reset_mid_search();
      test_restart_in_done();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/n_search.md
# n_search

Binary-search controller that drives the other side of the `n_comp` magnitude-comparator interface. On `start`, it proposes a guess on the comparator's `b` operand. It then consumes the `gt`/`eq`/`lt` feedback, where `a` is the hidden secret, and narrows the candidate range until `eq` identifies the secret. It sits beside `n_comp` in the number-guessing datapath: `n_comp` reports the comparison, and this block decides the next guess.

## Interface
- `WIDTH`, default 4: operand width; the candidate range is 0 .. 2^WIDTH-1.
- `STEP_W`, default 4: width of the probe counter; it must hold WIDTH+1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request to begin a new search; honoured in IDLE, DONE and ERR, ignored in PROBE.
- `guess`  out  WIDTH  current probe value; connects to `n_comp.b`.
- `guess_valid`  out  1  high while `guess` awaits feedback.
- `fb_valid`  in  1  feedback qualifier; `gt`/`eq`/`lt` are sampled only when `fb_valid` and `guess_valid` are both high.
- `gt`  in  1  secret > guess.
- `eq`  in  1  secret == guess.
- `lt`  in  1  secret < guess.
- `busy`  out  1  high in PROBE.
- `done`  out  1  level, high in DONE.
- `err`  out  1  level, high in ERR.
- `found`  out  WIDTH  secret value, valid while `done` is high.
- `steps`  out  STEP_W  number of accepted probes in the current or last search.

## Operation
- **States:** IDLE, PROBE, DONE, ERR. Reset enters IDLE.
- **Reset values:** `guess`=0, `guess_valid`=0, `busy`=0, `done`=0, `err`=0, `found`=0, `steps`=0, internal `lo`=0, internal `hi`=0.
- **Start (from IDLE/DONE/ERR):** `start`=1 sets `lo`=0, `hi`=2^WIDTH-1 and `steps`=0, clears `done`/`err`/`found`, then enters PROBE.
- **PROBE outputs:** `guess` = mid = (lo+hi)>>1, with the sum computed at WIDTH+1 bits and no overflow. `guess_valid`=1 and `busy`=1.
- **Accepted feedback:** every accepted feedback cycle increments `steps`. Flags are decoded as follows:
  - exactly `eq`: `found`=mid, go to DONE.
  - exactly `gt`: if mid==hi, go to ERR; else `lo`=mid+1 and stay in PROBE.
  - exactly `lt`: if mid==lo, go to ERR; else `hi`=mid-1 and stay in PROBE.
  - zero flags, or more than one flag set: go to ERR, with `lo`/`hi` unchanged.
- **Stalled feedback:** `fb_valid`=0 in PROBE holds all state and outputs.
- **Start during PROBE:** `start` is ignored.
- **Feedback outside PROBE:** `fb_valid` is ignored in IDLE, DONE and ERR.
- **DONE/ERR:** hold `found`, `steps`, `lo` and `hi`, with `guess_valid`=0, until `start` or reset.
- **Restart precedence:** `start` in DONE/ERR restarts immediately. The same cycle's `fb_valid` is ignored.
- **Arithmetic rules:** `lo` and `hi` are WIDTH bits. The mid==lo and mid==hi checks guarantee mid±1 never wraps. The invariant lo ≤ mid ≤ hi holds in PROBE.
- **Worst case:** a consistent responder finishes in at most WIDTH+1 probes. `steps` saturates at 2^STEP_W-1 and never wraps.

## Timing
- **Start latency:** `start` sampled at edge N puts the first guess on `guess` with `guess_valid`=1 after edge N.
- **Zero-wait responder:** feedback accepted at edge K updates `guess` after edge K. With `n_comp` in the loop and `fb_valid` tied to `guess_valid`, there is one probe per cycle.
- **Status outputs:** `done` and `err` assert in the cycle after the deciding feedback edge, together with `guess_valid` deasserting.
- **Registered outputs:** all outputs are registered, with no combinational path from `gt`/`eq`/`lt` to any output.
- **Asynchronous reset:** asserting `rst_n` low at any time, including mid-PROBE, forces the reset values immediately. The first edge after release acts as IDLE.

## Test plan
- Secret 11, WIDTH=4, `n_comp` in loop, `fb_valid`=`guess_valid` -> guesses 7, 11; `done`=1, `found`=11, `steps`=2, `err`=0.
- Secret 0 -> guesses 7, 3, 1, 0; `found`=0, `steps`=4. Secret 15 -> guesses 7, 11, 13, 14, 15; `steps`=5 (worst case).
- Scripted responder always answering `gt` -> guesses 7, 11, 13, 14, 15; then `err`=1 with `steps`=5 and no wrap to 0.
- Illegal feedback: `gt`=`lt`=1 on the first probe -> `err`=1, `steps`=1. A separate run with all flags 0 and `fb_valid`=1 -> `err`=1.
- Stall and start-in-PROBE: `fb_valid` low for 3 cycles holds `guess`=7 and `steps`=0, and `start` pulsed during the stall is ignored. After the stall, feedback `lt` -> `guess`=3.
- Reset and restart:
  - `rst_n` low mid-search (after guess 11) -> all outputs at reset values before the next edge.
  - After release, `start` with secret 5 -> guesses 7, 3, 5; `found`=5.
  - `start` while in DONE -> immediate restart with `guess`=7.
